// File: rtl/pipe_core_p.sv
// Four-stage (F, D, E, W) in-order pipelined core with forwarding, regfile
// write-through bypass, taken-branch flushing and a global pipeline enable.
module pipe_core_p #(
  parameter int DATA_W = 8,
  parameter int REG_N  = 8,
  parameter int IMM_W  = 3,
  parameter int PC_W   = 6,
  localparam int RA_W   = $clog2(REG_N),
  localparam int INST_W = 2 + RA_W + IMM_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_data,
  output logic              wb_valid,
  output logic [RA_W-1:0]   wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              br_taken
);

  typedef enum logic [1:0] {
    OP_LI   = 2'b00,
    OP_ADDI = 2'b01,
    OP_BZ   = 2'b10,
    OP_J    = 2'b11
  } op_t;

  logic [PC_W-1:0]   pc;
  logic              ifid_valid;
  logic [INST_W-1:0] ifid_inst;
  logic              idex_valid;
  logic [INST_W-1:0] idex_inst;
  logic [DATA_W-1:0] idex_val;
  logic              exwb_valid;
  logic [RA_W-1:0]   exwb_rd;
  logic [DATA_W-1:0] exwb_data;
  logic [DATA_W-1:0] regs [REG_N];

  logic [RA_W-1:0]      d_rd;
  logic [DATA_W-1:0]    d_val;
  op_t                  e_op;
  logic [RA_W-1:0]      e_rd;
  logic [IMM_W-1:0]     e_imm;
  logic [RA_W+IMM_W-1:0] e_tgt;
  logic [DATA_W-1:0]    e_opnd;
  logic [DATA_W-1:0]    e_result;
  logic                 e_write;
  logic                 e_redirect;
  logic [PC_W-1:0]      e_target;

  assign d_rd  = ifid_inst[INST_W-3 -: RA_W];
  assign d_val = (wb_valid && (exwb_rd == d_rd)) ? exwb_data : regs[d_rd];

  assign e_op   = op_t'(idex_inst[INST_W-1 -: 2]);
  assign e_rd   = idex_inst[INST_W-3 -: RA_W];
  assign e_imm  = idex_inst[IMM_W-1:0];
  assign e_tgt  = idex_inst[RA_W+IMM_W-1:0];
  // A branch tests the forwarded operand, so a write still in W decides it.
  assign e_opnd = (exwb_valid && (exwb_rd == e_rd)) ? exwb_data : idex_val;

  always_comb begin
    e_result   = '0;
    e_write    = 1'b0;
    e_redirect = 1'b0;
    e_target   = '0;
    case (e_op)
      OP_LI: begin
        e_result = DATA_W'(e_imm);
        e_write  = idex_valid;
      end
      OP_ADDI: begin
        e_result = e_opnd + DATA_W'(e_imm);
        e_write  = idex_valid;
      end
      OP_BZ: begin
        e_redirect = idex_valid && (e_opnd == '0);
        e_target   = PC_W'(e_imm);
      end
      OP_J: begin
        e_redirect = idex_valid;
        e_target   = PC_W'(e_tgt);
      end
      default: ;
    endcase
  end

  // A redirect squashes the two younger instructions sitting in IF/ID and ID/EX.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc         <= '0;
      ifid_valid <= 1'b0;
      ifid_inst  <= '0;
      idex_valid <= 1'b0;
      idex_inst  <= '0;
      idex_val   <= '0;
      exwb_valid <= 1'b0;
      exwb_rd    <= '0;
      exwb_data  <= '0;
    end else if (en) begin
      pc         <= e_redirect ? e_target : pc + PC_W'(1);
      ifid_valid <= !e_redirect;
      ifid_inst  <= imem_data;
      idex_valid <= ifid_valid && !e_redirect;
      idex_inst  <= ifid_inst;
      idex_val   <= d_val;
      exwb_valid <= e_write;
      exwb_rd    <= e_rd;
      exwb_data  <= e_result;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_N; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_valid) begin
      regs[exwb_rd] <= exwb_data;
    end
  end

  assign imem_addr = pc;
  assign wb_valid  = exwb_valid && en;
  assign wb_reg    = exwb_rd;
  assign wb_data   = exwb_data;
  assign br_taken  = e_redirect;

endmodule

// File: tb/tb_pipe_core_p.sv
// Self-checking bench for pipe_core_p: an 8-bit and a 4-bit instance share one
// instruction memory and are compared cycle by cycle against an ISA-level model.
module tb_pipe_core_p;

  localparam int MAXC = 400;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] imem [64];
  logic [5:0] addr8, addr4;
  logic [7:0] data8, data4;
  logic       wv8, wv4, br8, br4;
  logic [2:0] wr8, wr4;
  logic [7:0] wd8;
  logic [3:0] wd4;

  assign data8 = imem[addr8];
  assign data4 = imem[addr4];

  pipe_core_p u_dut (
    .clk(clk), .reset(reset), .en(en),
    .imem_addr(addr8), .imem_data(data8),
    .wb_valid(wv8), .wb_reg(wr8), .wb_data(wd8), .br_taken(br8)
  );

  pipe_core_p #(.DATA_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .en(en),
    .imem_addr(addr4), .imem_data(data4),
    .wb_valid(wv4), .wb_reg(wr4), .wb_data(wd4), .br_taken(br4)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Expected per-cycle behaviour, indexed by [instance][enabled cycles since reset].
  int exp_addr [2][MAXC];
  bit exp_br   [2][MAXC];
  bit exp_wv   [2][MAXC];
  int exp_wr   [2][MAXC];
  int exp_wd   [2][MAXC];

  // Executes the program architecturally; an instruction fetched at cycle c
  // writes back at c+3, and a taken branch costs two wrong-path fetches.
  task automatic build_model(input int w, input int dw);
    int r [8];
    int c, pc, inst, op, rd, imm, target;
    bit taken;
    for (int i = 0; i < MAXC; i++) begin
      exp_addr[w][i] = 0;
      exp_br[w][i]   = 0;
      exp_wv[w][i]   = 0;
      exp_wr[w][i]   = 0;
      exp_wd[w][i]   = 0;
    end
    for (int i = 0; i < 8; i++) r[i] = 0;
    c  = 0;
    pc = 0;
    while (c < MAXC) begin
      inst   = int'(imem[pc]);
      op     = (inst >> 6) & 3;
      rd     = (inst >> 3) & 7;
      imm    = inst & 7;
      taken  = 0;
      target = 0;
      exp_addr[w][c] = pc;
      if (op < 2) begin
        r[rd] = (op == 0) ? imm : (r[rd] + imm) % (1 << dw);
        if (c + 3 < MAXC) begin
          exp_wv[w][c+3] = 1;
          exp_wr[w][c+3] = rd;
          exp_wd[w][c+3] = r[rd];
        end
      end else if (op == 2) begin
        taken  = (r[rd] == 0);
        target = imm;
      end else begin
        taken  = 1;
        target = inst & 63;
      end
      if (taken) begin
        if (c + 1 < MAXC) exp_addr[w][c+1] = (pc + 1) % 64;
        if (c + 2 < MAXC) begin
          exp_addr[w][c+2] = (pc + 2) % 64;
          exp_br[w][c+2]   = 1;
        end
        c  = c + 3;
        pc = target;
      end else begin
        c  = c + 1;
        pc = (pc + 1) % 64;
      end
    end
  endtask

  task automatic load_prog(input logic [7:0] prog [$]);
    for (int i = 0; i < 64; i++) imem[i] = 8'h00;
    foreach (prog[i]) imem[i] = prog[i];
    build_model(0, 8);
    build_model(1, 4);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    en    = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({addr8, wv8, wr8, wd8, br8} !== 19'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs dut8: got %h want 0", {addr8, wv8, wr8, wd8, br8});
    end
    n_cmp++;
    if ({addr4, wv4, wr4, wd4, br4} !== 15'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs dut4: got %h want 0", {addr4, wv4, wr4, wd4, br4});
    end
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // mode 0: en always 1; mode 1: random en; mode 2: en low for cycles 6..8.
  task automatic run_check(input string tag, input int ncyc, input int mode);
    int k;
    logic [7:0] o_a, o_wd;
    logic [2:0] o_wr;
    logic o_br, o_wv;
    bit e_wv;
    k = 0;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      case (mode)
        0:       en = 1'b1;
        1:       en = ($urandom_range(0, 3) != 0);
        default: en = !(cyc >= 6 && cyc < 9);
      endcase
      @(negedge clk);
      for (int w = 0; w < 2; w++) begin
        o_a  = (w == 1) ? {2'b00, addr4} : {2'b00, addr8};
        o_br = (w == 1) ? br4 : br8;
        o_wv = (w == 1) ? wv4 : wv8;
        o_wr = (w == 1) ? wr4 : wr8;
        o_wd = (w == 1) ? {4'h0, wd4} : wd8;
        e_wv = en && exp_wv[w][k];
        n_cmp++;
        if (o_a !== 8'(exp_addr[w][k])) begin
          n_fail++;
          $display("[TB] FAIL %s imem_addr dut%0d cyc %0d: got %0d want %0d", tag, w, cyc, o_a, exp_addr[w][k]);
        end
        n_cmp++;
        if (o_br !== exp_br[w][k]) begin
          n_fail++;
          $display("[TB] FAIL %s br_taken dut%0d cyc %0d: got %b want %b", tag, w, cyc, o_br, exp_br[w][k]);
        end
        n_cmp++;
        if (o_wv !== e_wv) begin
          n_fail++;
          $display("[TB] FAIL %s wb_valid dut%0d cyc %0d: got %b want %b", tag, w, cyc, o_wv, e_wv);
        end
        if (e_wv) begin
          n_cmp++;
          if (o_wr !== 3'(exp_wr[w][k]) || o_wd !== 8'(exp_wd[w][k])) begin
            n_fail++;
            $display("[TB] FAIL %s wb dut%0d cyc %0d: got r%0d=%0d want r%0d=%0d", tag, w, cyc, o_wr, o_wd, exp_wr[w][k], exp_wd[w][k]);
          end
        end
      end
      @(posedge clk);
      if (en) k++;
      #1;
    end
  endtask

  task automatic test_reset();
    load_prog('{8'h0D});
    do_reset();
    run_check("reset_li", 8, 0);
  endtask

  task automatic test_forwarding();
    load_prog('{8'h0D, 8'h4B, 8'h4B});
    do_reset();
    run_check("forwarding", 10, 0);
  endtask

  task automatic test_wrap();
    load_prog('{8'h0F, 8'h4F, 8'h4F});
    do_reset();
    run_check("wrap", 10, 0);
  endtask

  task automatic test_jump();
    load_prog('{8'hD0, 8'h11, 8'h19});
    imem[16] = 8'h22;
    build_model(0, 8);
    build_model(1, 4);
    do_reset();
    run_check("jump", 12, 0);
  endtask

  task automatic test_bz();
    load_prog('{8'h94, 8'h00, 8'h00, 8'h00, 8'h11, 8'h94});
    do_reset();
    run_check("bz", 14, 0);
  endtask

  task automatic test_enable_stall();
    load_prog('{8'h0D, 8'h4B, 8'h4B, 8'h4B, 8'h4B, 8'h4B, 8'h4B, 8'h4B, 8'h4B, 8'h4B});
    do_reset();
    run_check("stall", 18, 2);
  endtask

  task automatic test_async_reset();
    load_prog('{8'h4B, 8'h4B, 8'h4B, 8'h4B, 8'h4B, 8'h4B, 8'h4B, 8'h4B});
    do_reset();
    run_check("pre_reset", 7, 0);
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({addr8, wv8, wr8, wd8, br8} !== 19'd0) begin
      n_fail++;
      $display("[TB] FAIL async_reset dut8: got %h want 0", {addr8, wv8, wr8, wd8, br8});
    end
    n_cmp++;
    if ({addr4, wv4, wr4, wd4, br4} !== 15'd0) begin
      n_fail++;
      $display("[TB] FAIL async_reset dut4: got %h want 0", {addr4, wv4, wr4, wd4, br4});
    end
    do_reset();
    run_check("post_reset", 10, 0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 64; i++) imem[i] = 8'($urandom);
      build_model(0, 8);
      build_model(1, 4);
      do_reset();
      run_check("random", 150, 1);
    end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_wrap();
    test_jump();
    test_bz();
    test_enable_stall();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_core_p.md
# pipe_core_p

Parametrised successor to the team's 3-stage 8-bit pipelined core. It is a four-stage in-order pipeline (F, D, E, W) with:
- a general register file of REG_N entries of DATA_W bits;
- full EX/WB forwarding and regfile write-through bypass;
- taken-branch flushing and a new conditional branch (BZ);
- a global pipeline enable.

Instruction memory is external and read asynchronously through imem_addr/imem_data. The default parameters reproduce the team's existing 8-bit instruction format.

## Interface
Parameters:
- DATA_W, 8, register/ALU width (≥2)
- REG_N, 8, register count, power of two ≥2; RA_W = clog2(REG_N)
- IMM_W, 3, immediate width (≥1, ≤DATA_W)
- PC_W, 6, program counter width; INST_W = 2+RA_W+IMM_W

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- en  in  1  pipeline enable; when 0, all state holds
- imem_addr  out  PC_W  current PC (fetch address)
- imem_data  in  INST_W  instruction at imem_addr, valid same cycle (combinational)
- wb_valid  out  1  a register write occurs at this cycle's edge
- wb_reg  out  RA_W  destination of the write
- wb_data  out  DATA_W  value written
- br_taken  out  1  E-stage branch/jump redirect this cycle

## Operation
- Instruction fields: op=[INST_W-1:INST_W-2], rd=next RA_W bits, imm=low IMM_W bits. tgt = [RA_W+IMM_W-1:0].
- 00 LI: rd ← zext(imm).
- 01 ADDI: rd ← rd + zext(imm), modulo 2^DATA_W.
- 10 BZ: if rd == 0, PC ← zext/trunc(imm) to PC_W; no write.
- 11 J: PC ← tgt zero-extended or truncated to PC_W; no write.
- F: PC drives imem_addr; instruction captured in IF/ID with valid bit; PC ← PC+1, wrapping 2^PC_W−1→0.
- D: decode, read rd from regfile. If W writes the same reg this cycle, the bypass returns the new value. Result captured in ID/EX.
- E: operand = EX/WB result if EX/WB is a valid write to the same rd, else the ID/EX value. ALU computes; BZ tests the operand (after forwarding). Result captured in EX/WB.
- W: EX/WB drives wb_*; the regfile is written at the edge when wb_valid=1.
- Redirect: a valid BZ-taken or J in E asserts br_taken.
  - At that edge: PC ← target, and IF/ID and ID/EX valid ← 0 (two bubbles).
  - The redirect overrides PC+1.
- Invalid (bubble) stages perform no write and no redirect.
- en=0: PC, all pipeline registers and the regfile hold, and the regfile write is suppressed. Outputs remain combinational from held state, but wb_valid is forced to 0 while en=0.

## Timing
- Reset: PC=0, all stage valids 0, all registers 0. Outputs: imem_addr=0, wb_valid=0, wb_reg=0, wb_data=0, br_taken=0.
- Reset is asynchronous mid-operation: all of the above apply immediately and in-flight instructions are discarded.
- Instruction at imem_addr in cycle t:
  - D in t+1, E in t+2, wb_valid in t+3.
  - Regfile updated at the end of t+3.
- Back-to-back dependent instructions need no stalls; throughput is 1 instruction/cycle.
- Taken branch fetched in cycle t: br_taken in t+2, target on imem_addr in t+3. Penalty is 2 cycles.
- Branch in E while EX/WB writes its rd: the forwarded value decides the branch.

## Test plan
Defaults unless stated. Encodings: LI r1,5=0x0D; ADDI r1,3=0x4B; J 16=0xD0; LI r2,1=0x11; LI r3,1=0x19; LI r4,2=0x22; BZ r2,#4=0x94.
- Reset then imem[0]=0x0D → wb_valid=1, wb_reg=1, wb_data=5 in the 4th cycle after reset release; all outputs are 0 during reset.
- imem 0x0D,0x4B,0x4B (forwarding) → wb_data 5, 8, 11 on three consecutive cycles.
- DATA_W=4: LI r1,7; ADDI r1,7; ADDI r1,7 → wb_data 7, 14, 5 (wrap).
- Jump: imem[0]=0xD0, [1]=0x11, [2]=0x19, [16]=0x22 → imem_addr sequence 0,1,2,16,17; br_taken pulses once; r2 and r3 are never written; the first wb is r4=2.
- BZ: imem[0]=0x94 with r2=0 → taken, imem_addr 0,1,2,4. Then with r2=1 (LI at [4], BZ at [5]): not taken, sequential fetch.
- en=0 for 3 cycles mid-stream → no state change and wb_valid=0. On en=1, the wb_data sequence resumes unchanged. Separately, reset asserted mid-stream → outputs are 0 at once and execution restarts at PC 0.
